// File: rtl/dmem_dump.sv
// Data memory for the pipelined LEGv8 core with a valid/ready dump port that
// streams every word out in index order after a rising edge on dump.
module dmem_dump #(
   parameter  int N     = 64,
   parameter  int DEPTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          DM_writeEnable,
   input  logic          DM_readEnable,
   input  logic [N-1:0]  DM_addr,
   input  logic [N-1:0]  DM_writeData,
   output logic [N-1:0]  readData,
   input  logic          dump,
   output logic          dump_valid,
   input  logic          dump_ready,
   output logic [AW-1:0] dump_addr,
   output logic [N-1:0]  dump_data,
   output logic          dump_done
);

   typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

   logic [N-1:0]  mem_q [DEPTH];
   state_t        state_q;
   logic [AW-1:0] cnt_q;
   logic [AW-1:0] cntNext;
   logic          dump_q;
   logic          valid_q;
   logic          done_q;
   logic [AW-1:0] addr_q;
   logic [N-1:0]  data_q;
   logic [AW-1:0] memIdx;
   logic          dumpRise;
   logic          unusedAddr;

   // Byte offset and bits above the word index are dropped, so addresses alias.
   assign memIdx     = DM_addr[AW+2:3];
   assign unusedAddr = ^{DM_addr[N-1:AW+3], DM_addr[2:0]};
   assign cntNext    = cnt_q + AW'(1);
   assign dumpRise   = dump & ~dump_q;

   assign readData   = DM_readEnable ? mem_q[memIdx] : '0;
   assign dump_valid = valid_q;
   assign dump_done  = done_q;
   assign dump_addr  = addr_q;
   assign dump_data  = data_q;

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (DM_writeEnable) begin
         mem_q[memIdx] <= DM_writeData;
      end
   end

   // The presented word is captured into data_q, so a store to that word
   // while the consumer stalls cannot disturb the beat on the port.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dump_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         dump_q <= dump;
         unique case (state_q)
            IDLE: begin
               if (dumpRise) begin
                  cnt_q   <= '0;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               data_q  <= mem_q[cnt_q];
               addr_q  <= cnt_q;
               valid_q <= 1'b1;
               state_q <= STREAM;
            end
            STREAM: begin
               if (valid_q && dump_ready) begin
                  if (cnt_q == AW'(DEPTH - 1)) begin
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     cnt_q  <= cntNext;
                     data_q <= mem_q[cntNext];
                     addr_q <= cntNext;
                  end
               end
            end
            DONE: begin
               if (!dump) begin
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_dump.sv
// Randomized bench for dmem_dump: a word-array memory model plus a beat
// scoreboard that predicts every readData and dump-port value cycle by cycle.
module tb_dmem_dump;

   localparam int N     = 64;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic          CLOCK_50;
   logic          reset;
   logic          DM_writeEnable;
   logic          DM_readEnable;
   logic [N-1:0]  DM_addr;
   logic [N-1:0]  DM_writeData;
   logic [N-1:0]  readData;
   logic          dump;
   logic          dump_valid;
   logic          dump_ready;
   logic [AW-1:0] dump_addr;
   logic [N-1:0]  dump_data;
   logic          dump_done;

   dmem_dump #(.N(N), .DEPTH(DEPTH)) dut (
      .CLOCK_50       (CLOCK_50),
      .reset          (reset),
      .DM_writeEnable (DM_writeEnable),
      .DM_readEnable  (DM_readEnable),
      .DM_addr        (DM_addr),
      .DM_writeData   (DM_writeData),
      .readData       (readData),
      .dump           (dump),
      .dump_valid     (dump_valid),
      .dump_ready     (dump_ready),
      .dump_addr      (dump_addr),
      .dump_data      (dump_data),
      .dump_done      (dump_done)
   );

   // Free-running 100 MHz-style clock
   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   int          total;
   int          bad;
   logic [63:0] model [DEPTH];
   bit          expValid;
   bit          expDone;
   bit          armLoad;
   bit          dumping;
   bit          prevDump;
   logic [4:0]  expAddr;
   logic [63:0] expData;
   int          dutAccepts;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Wipe the bench's picture of the design, as a reset does
   task automatic clearModel();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      expValid = 0;
      expDone  = 0;
      armLoad  = 0;
      dumping  = 0;
      prevDump = 0;
      expAddr  = '0;
      expData  = '0;
   endtask

   // One clock cycle: drive inputs, check at the falling edge, predict the
   // next cycle, then commit any store to the model at the rising edge.
   task automatic applyStimulus(input bit we, input logic [63:0] addr, input logic [63:0] wd,
                                input bit re, input bit rdy, input bit dmp);
      DM_writeEnable = we;
      DM_addr        = addr;
      DM_writeData   = wd;
      DM_readEnable  = re;
      dump_ready     = rdy;
      dump           = dmp;
      @(negedge CLOCK_50);
      checkOutput("readData", readData, re ? model[addr[7:3]] : 64'd0);
      checkOutput("dump_valid", {63'd0, dump_valid}, {63'd0, expValid});
      checkOutput("dump_done", {63'd0, dump_done}, {63'd0, expDone});
      if (expValid) begin
         checkOutput("dump_addr", {59'd0, dump_addr}, {59'd0, expAddr});
         checkOutput("dump_data", dump_data, expData);
      end
      if (dump_valid && dump_ready) dutAccepts++;
      if (expDone && !dmp) begin
         expDone = 0;
         dumping = 0;
      end
      if (armLoad) begin
         armLoad  = 0;
         expValid = 1;
         expAddr  = 0;
         expData  = model[0];
      end else if (expValid && rdy) begin
         if (expAddr == 5'd31) begin
            expValid = 0;
            expDone  = 1;
         end else begin
            expAddr = expAddr + 5'd1;
            expData = model[expAddr];
         end
      end
      if (dmp && !prevDump && !dumping) begin
         dumping = 1;
         armLoad = 1;
      end
      prevDump = dmp;
      @(posedge CLOCK_50);
      if (we) model[addr[7:3]] = wd;
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(0, 64'd0, 64'd0, 0, 0, 0);
   endtask

   // mode 0: ready high, 1: one high/two low, 2: random ready
   task automatic runDump(input int mode, input bit retrigger, input int abortAt, input bit randWrites);
      bit          rdy;
      bit          dmp;
      bit          we;
      logic [63:0] addr;
      logic [63:0] wd;
      bit          aborted;
      int          cyc;
      dutAccepts = 0;
      aborted    = 0;
      cyc        = 0;
      while (cyc < 300 && !(expDone && cyc > 2)) begin
         case (mode)
            0:       rdy = 1;
            1:       rdy = (cyc % 3 == 0);
            default: rdy = $urandom_range(0, 1) == 1;
         endcase
         dmp = !(retrigger && (cyc == 8 || cyc == 9));
         we   = randWrites && ($urandom_range(0, 1) == 1);
         addr = {$urandom, $urandom};
         wd   = {$urandom, $urandom};
         if (mode == 1 && expValid && !rdy && randWrites) begin
            we   = 1;
            addr = {56'd0, expAddr, 3'd0};
         end
         applyStimulus(we, addr, wd, $urandom_range(0, 1) == 1, rdy, dmp);
         cyc++;
         if (abortAt >= 0 && dutAccepts == abortAt) begin
            aborted = 1;
            break;
         end
      end
      if (aborted) begin
         dump          = 0;
         reset         = 0;
         DM_readEnable = 1;
         DM_addr       = 64'h10;
         #1;
         checkOutput("abort_valid", {63'd0, dump_valid}, 64'd0);
         checkOutput("abort_done", {63'd0, dump_done}, 64'd0);
         checkOutput("abort_mem", readData, 64'd0);
         clearModel();
         @(negedge CLOCK_50);
         reset = 1;
         @(posedge CLOCK_50);
         #1;
      end else begin
         checkOutput("done_seen", {63'd0, dump_done}, 64'd1);
         checkOutput("beat_count", dutAccepts, 64'd32);
         for (int i = 0; i < 3; i++) applyStimulus(0, 64'd0, 64'd0, 0, 1, 1);
         for (int i = 0; i < 3; i++) idleCycle();
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      dutAccepts = 0;
      clearModel();
      reset          = 0;
      DM_writeEnable = 0;
      DM_readEnable  = 0;
      DM_addr        = '0;
      DM_writeData   = '0;
      dump           = 0;
      dump_ready     = 0;
      #1;
      checkOutput("rst_valid", {63'd0, dump_valid}, 64'd0);
      checkOutput("rst_done", {63'd0, dump_done}, 64'd0);
      checkOutput("rst_addr", {59'd0, dump_addr}, 64'd0);
      checkOutput("rst_data", dump_data, 64'd0);
      repeat (2) @(negedge CLOCK_50);
      reset = 1;
      @(posedge CLOCK_50);
      #1;

      $display("[TB] reset contents");
      for (int i = 0; i < DEPTH; i++) applyStimulus(0, 64'(i * 8), 64'd0, 1, 0, 0);

      $display("[TB] store/load and aliasing");
      applyStimulus(1, 64'h10, 64'hDEADBEEF_00000001, 1, 0, 0);
      applyStimulus(0, 64'h10, 64'd0, 1, 0, 0);
      checkOutput("store_load", readData, 64'hDEADBEEF_00000001);
      applyStimulus(1, 64'h108, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
      applyStimulus(0, 64'h8, 64'd0, 1, 0, 0);
      checkOutput("alias_word1", readData, 64'h0123_4567_89AB_CDEF);
      for (int i = 0; i < 20; i++)
         applyStimulus($urandom_range(0, 1) == 1, {$urandom, $urandom}, {$urandom, $urandom}, 1, 0, 0);

      $display("[TB] full dump, ready high");
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 64'(i * 8), 64'(i * 3), 0, 0, 0);
      runDump(0, 0, -1, 0);

      $display("[TB] backpressure");
      runDump(1, 0, -1, 1);

      $display("[TB] retrigger and random ready");
      runDump(2, 1, -1, 1);

      $display("[TB] abort by reset");
      runDump(0, 0, 10, 1);
      runDump(2, 0, -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_dump.md
# dmem_dump

Data memory for the pipelined ARM (LEGv8) processor: it consumes the core's data-memory write stream (`DM_writeData`, `DM_addr`, `DM_writeEnable`) and serves load data back. On a `dump` request it runs a sequential engine that streams every memory word out over a valid/ready port. The bench and FPGA debug logic use this port to check final memory state after a program run.

## Interface
- `N`, 64: data and address width in bits.
- `DEPTH`, 32: number of 64-bit words; must be a power of two.
- `AW`, $clog2(DEPTH): word-index width; derived, not overridden.

Ports:
- `CLOCK_50`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `DM_writeEnable`  in  1  store strobe from the core.
- `DM_readEnable`  in  1  load strobe from the core; gates `readData`.
- `DM_addr`  in  N  byte address; word index = `DM_addr[AW+2:3]`.
- `DM_writeData`  in  N  store data.
- `readData`  out  N  load data.
- `dump`  in  1  dump request; level signal, acted on at its rising edge.
- `dump_valid`  out  1  `dump_addr`/`dump_data` hold a word.
- `dump_ready`  in  1  consumer accepts the current word.
- `dump_addr`  out  AW  word index of the current dump word.
- `dump_data`  out  N  content of the current dump word.
- `dump_done`  out  1  all DEPTH words accepted.

## Operation
- Storage is DEPTH x N registers. Reset clears every word to 0.
- Writes:
  - If `DM_writeEnable` is 1 at a rising edge, `mem[idx] <= DM_writeData`.
  - `DM_addr[2:0]` and bits above `AW+2` are ignored, so out-of-range addresses wrap modulo DEPTH.
- Reads:
  - Combinational: `readData = DM_readEnable ? mem[idx] : 0`.
  - A write and a read to the same word in the same cycle return the old value until the edge.
- Dump FSM, with states IDLE, LOAD, STREAM, DONE:
  - `dump` is registered (`dump_q`) for edge detection. A rise is `dump & ~dump_q`.
  - IDLE: on a rise, clear the index counter and go to LOAD. Otherwise stay.
  - LOAD: register `dump_data <= mem[cnt]` and `dump_addr <= cnt`, set `dump_valid = 1`, go to STREAM.
  - STREAM, while `dump_valid & ~dump_ready`: hold `dump_addr` and `dump_data` stable, even if the core writes that same word.
  - STREAM, on accept (`dump_valid & dump_ready`):
    - If `cnt == DEPTH-1`: clear `dump_valid`, set `dump_done`, go to DONE.
    - Otherwise: increment `cnt` and load the next word directly (`dump_valid` stays 1), so a continuous `dump_ready` gives one word per cycle.
  - DONE: hold `dump_done = 1` while `dump` is 1. When `dump` is 0, clear `dump_done` and go to IDLE.
- Rules during a dump:
  - The dump is a live read, not a snapshot. A word written before it is loaded appears with its new value; a word written after it is loaded does not.
  - A `dump` rise while in LOAD, STREAM or DONE is ignored. Dropping `dump` mid-stream does not abort the stream.
  - Core writes and reads proceed normally in every state.
- Reset asserted mid-dump: FSM goes to IDLE, all outputs clear, memory clears.
- The counter is AW bits wide and never wraps past DEPTH-1; the terminal test stops it there.

## Timing
- Reset values: `readData` = 0 (memory cleared), `dump_valid` 0, `dump_addr` 0, `dump_data` 0, `dump_done` 0, FSM IDLE, `dump_q` 0.
- Write latency: 1 edge. Read latency: 0 cycles (combinational).
- Dump latency:
  - `dump` rise sampled at edge k: LOAD during cycle k..k+1.
  - `dump_valid` is 1 after edge k+1, with word 0 presented.
- Throughput: with `dump_ready` held at 1, word i is presented in cycle k+1+i.
- `dump_done` rises after edge k+1+DEPTH, i.e. DEPTH+1 cycles after the sampled rise.
- `dump_valid` never drops while a word is unaccepted.

## Test plan
1. **Reset:** release `reset` (0→1) with no other activity. Expect `readData` = 0 at every address and all dump outputs at 0.
2. **Store/load:**
   - Write 0xDEADBEEF_00000001 to byte address 0x10; read it back the next cycle.
   - Write to address 0x108. With DEPTH=32 this aliases word 1, which must read back the same data.
3. **Full dump, ready tied high:**
   - Preload `mem[i] = i*3`, pulse `dump`.
   - Expect 32 consecutive beats with `dump_addr` 0..31 and `dump_data` = i*3.
   - Expect `dump_done` one cycle after the last beat, staying high until `dump` goes to 0.
4. **Backpressure:**
   - Drive `dump_ready` in a pattern of 1 cycle high, 2 cycles low.
   - Expect `dump_data`/`dump_addr` stable while stalled, no word dropped or duplicated, 32 accepts total.
   - A write to the stalled word during the stall must not change `dump_data`.
5. **Retrigger and abort:**
   - A second `dump` rise mid-stream is ignored, giving exactly 32 beats.
   - Asserting `reset` (0) at beat 10 clears `dump_valid`, `dump_done` and memory immediately.
   - After release, a new dump outputs 32 zero words.
